// File: rtl/seq_detector.sv
// ----------------------------------------------------------------------------
// seq_detector
//
// Serial bit-pattern detector. Sits directly after the D flip-flop sampling
// stage and takes that flop's registered q as din. Qualified bits shift into
// a history register; when the newest PATTERN_W bits equal PATTERN, a
// one-cycle det pulse is produced and a saturating match counter advances.
//
// Build option:
//   SEQ_DET_NONOVERLAP_EN  when defined, a match clears the history and the
//                          fill counter, so the next match needs PATTERN_W
//                          new bits. When undefined, detection overlaps.
//
// Ports:
//   clk      system clock, all state updates on posedge
//   rst      synchronous active-high reset, priority over everything
//   din_en   qualifies din; when low all state holds and det drops
//   din      serial data bit
//   det      registered match pulse, one cycle per match
//   det_cnt  saturating count of matches since reset
//   hist     history register, newest bit at LSB (debug view)
// ----------------------------------------------------------------------------
module seq_detector #(
   parameter int                   PATTERN_W = 4,
   parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011,
   parameter int                   CNT_W     = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 din_en,
   input  logic                 din,
   output logic                 det,
   output logic [CNT_W-1:0]     det_cnt,
   output logic [PATTERN_W-1:0] hist
);

   localparam int FILL_W = $clog2(PATTERN_W + 1);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PATTERN_W);
   // Fill level at which the incoming bit completes a full window.
   localparam logic [FILL_W-1:0] FILL_ARM = FILL_W'(PATTERN_W - 1);

   logic [PATTERN_W-1:0] hist_reg;
   logic [PATTERN_W-1:0] hist_next;
   logic [FILL_W-1:0]    fill_reg;
   logic                 det_reg;
   logic [CNT_W-1:0]     cnt_reg;
   logic [PATTERN_W-1:0] bit_eq;
   logic                 match;

   assign hist_next = {hist_reg[PATTERN_W-2:0], din};

   // Per-bit equality against the pattern; a match needs every bit equal.
   genvar gi;
   generate
      for (gi = 0; gi < PATTERN_W; gi++) begin : g_cmp
         assign bit_eq[gi] = ~(hist_next[gi] ^ PATTERN[gi]);
      end
   endgenerate

   // The fill qualifier stops the zero-filled history left by reset from
   // matching an all-zeros (or zero-prefixed) pattern early.
   assign match = (&bit_eq) && (fill_reg >= FILL_ARM);

   always_ff @(posedge clk) begin
      if (rst) begin
         hist_reg <= '0;
         fill_reg <= '0;
         det_reg  <= 1'b0;
         cnt_reg  <= '0;
      end else if (din_en) begin
         hist_reg <= hist_next;
         if (fill_reg < FILL_MAX) begin
            fill_reg <= fill_reg + FILL_W'(1);
         end
         det_reg <= match;
         if (match) begin
            if (!(&cnt_reg)) begin
               cnt_reg <= cnt_reg + CNT_W'(1);
            end
`ifdef SEQ_DET_NONOVERLAP_EN
            // Consume the matched bits so they cannot seed the next match.
            hist_reg <= '0;
            fill_reg <= '0;
`endif
         end
      end else begin
         det_reg <= 1'b0;
      end
   end

   assign det     = det_reg;
   assign det_cnt = cnt_reg;
   assign hist    = hist_reg;

endmodule
